// File: rtl/universal_shift_register_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : universal_shift_register_seq                                 |
// | Description : Parametrised universal shift register with hold, shift,      |
// |               rotate, arithmetic shift, load and clear. Multi-step shifts  |
// |               run under a start/busy/done handshake with clock enable.     |
// |               Optional macro USR_BARREL_EN: shift modes finish on the      |
// |               accept edge through a barrel shifter instead of the          |
// |               one-bit-per-cycle SHIFT state.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module universal_shift_register_seq #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              AW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] data,
   input  logic             sin,
   output logic [WIDTH-1:0] out,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] c_MODE_HOLD  = 3'b000;
   localparam logic [2:0] c_MODE_SRL   = 3'b001;
   localparam logic [2:0] c_MODE_SLL   = 3'b010;
   localparam logic [2:0] c_MODE_LOAD  = 3'b011;
   localparam logic [2:0] c_MODE_ROR   = 3'b100;
   localparam logic [2:0] c_MODE_ROL   = 3'b101;
   localparam logic [2:0] c_MODE_SRA   = 3'b110;
   localparam logic [2:0] c_MODE_CLEAR = 3'b111;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_out,   w_out_nxt;
   logic             r_sout,  w_sout_nxt;
   logic             r_busy,  w_busy_nxt;
   logic             r_done,  w_done_nxt;
   logic [AW-1:0]    r_count, w_count_nxt;
   logic [2:0]       r_mode,  w_mode_nxt;

   logic             w_is_shift;

   // Classify the requested mode: shift/rotate modes need the distance machinery.
   always_comb begin
      w_is_shift = 1'b0;
      case (mode)
         c_MODE_SRL, c_MODE_SLL, c_MODE_ROR, c_MODE_ROL, c_MODE_SRA: w_is_shift = 1'b1;
         default:                                                    w_is_shift = 1'b0;
      endcase
   end

`ifdef USR_BARREL_EN
   logic [2*WIDTH-1:0] w_cat;
   logic [WIDTH-1:0]   w_bar_out;
   logic               w_bar_sout;
   logic [AW-1:0]      w_ridx;
   logic [AW-1:0]      w_lidx;

   // Full-distance shift in one step: the last exiting bit is out[amt-1] for
   // right-going ops and out[WIDTH-amt] for left-going ops.
   always_comb begin
      w_cat      = '0;
      w_bar_out  = r_out;
      w_ridx     = amt - AW'(1);
      w_lidx     = AW'(WIDTH) - amt;
      w_bar_sout = r_sout;
      case (mode)
         c_MODE_SRL: begin
            w_cat      = {{WIDTH{sin}}, r_out} >> amt;
            w_bar_out  = w_cat[WIDTH-1:0];
            w_bar_sout = r_out[w_ridx];
         end
         c_MODE_SLL: begin
            w_cat      = {r_out, {WIDTH{sin}}} << amt;
            w_bar_out  = w_cat[2*WIDTH-1:WIDTH];
            w_bar_sout = r_out[w_lidx];
         end
         c_MODE_ROR: begin
            w_cat      = {r_out, r_out} >> amt;
            w_bar_out  = w_cat[WIDTH-1:0];
            w_bar_sout = r_out[w_ridx];
         end
         c_MODE_ROL: begin
            w_cat      = {r_out, r_out} << amt;
            w_bar_out  = w_cat[2*WIDTH-1:WIDTH];
            w_bar_sout = r_out[w_lidx];
         end
         c_MODE_SRA: begin
            w_cat      = {{WIDTH{r_out[WIDTH-1]}}, r_out} >> amt;
            w_bar_out  = w_cat[WIDTH-1:0];
            w_bar_sout = r_out[w_ridx];
         end
         default: begin
            w_cat      = '0;
            w_bar_out  = r_out;
            w_bar_sout = r_sout;
         end
      endcase
   end
`else
   logic [WIDTH-1:0] w_step_out;
   logic             w_step_sout;

   // Single-position move of the latched operation; sin is taken live each edge.
   always_comb begin
      w_step_out  = r_out;
      w_step_sout = r_sout;
      case (r_mode)
         c_MODE_SRL: begin
            w_step_out  = {sin, r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         c_MODE_SLL: begin
            w_step_out  = {r_out[WIDTH-2:0], sin};
            w_step_sout = r_out[WIDTH-1];
         end
         c_MODE_ROR: begin
            w_step_out  = {r_out[0], r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         c_MODE_ROL: begin
            w_step_out  = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            w_step_sout = r_out[WIDTH-1];
         end
         c_MODE_SRA: begin
            w_step_out  = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            w_step_sout = r_out[0];
         end
         default: begin
            w_step_out  = r_out;
            w_step_sout = r_sout;
         end
      endcase
   end
`endif

   // Next-state and datapath update; nothing advances without en, and done
   // defaults low so it always falls on the edge after it was raised.
   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_sout_nxt  = r_sout;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_count_nxt = r_count;
      w_mode_nxt  = r_mode;
      if (en) begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_mode_nxt = mode;
                  if (w_is_shift && (amt != '0)) begin
`ifdef USR_BARREL_EN
                     w_out_nxt  = w_bar_out;
                     w_sout_nxt = w_bar_sout;
                     w_done_nxt = 1'b1;
`else
                     w_count_nxt = amt;
                     w_busy_nxt  = 1'b1;
                     w_state_nxt = S_SHIFT;
`endif
                  end else begin
                     case (mode)
                        c_MODE_LOAD:  w_out_nxt = data;
                        c_MODE_CLEAR: w_out_nxt = '0;
                        default:      w_out_nxt = r_out;
                     endcase
                     w_done_nxt = 1'b1;
                  end
               end
            end
            S_SHIFT: begin
`ifndef USR_BARREL_EN
               w_out_nxt   = w_step_out;
               w_sout_nxt  = w_step_sout;
`endif
               w_count_nxt = r_count - AW'(1);
               if (r_count == AW'(1)) begin
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State register with asynchronous active-low reset that abandons any operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_out   <= RESET_VAL;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
         r_mode  <= c_MODE_HOLD;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_sout  <= w_sout_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_count <= w_count_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   assign out  = r_out;
   assign sout = r_sout;
   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_universal_shift_register_seq                              |
// | Description : Randomised self-checking bench for the universal shift       |
// |               register against a closed-form arithmetic reference.         |
// |               Honours USR_BARREL_EN for the expected timing.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_universal_shift_register_seq;

   logic       clk;
   logic       reset;
   logic       en;
   logic       start;
   logic [2:0] mode;
   logic [2:0] amt;
   logic [7:0] data;
   logic       sin;
   logic [7:0] out;
   logic       sout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Reference state: register contents and last exiting bit.
   int m_out;
   bit m_sout;

   universal_shift_register_seq #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .en(en), .start(start), .mode(mode), .amt(amt),
      .data(data), .sin(sin), .out(out), .sout(sout), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   function automatic bit is_shift(input logic [2:0] md);
      return (md == 3'd1) || (md == 3'd2) || (md == 3'd4) || (md == 3'd5) || (md == 3'd6);
   endfunction

   // Value of v after j single-position moves of mode md with constant fill s.
   function automatic int ref_out(input logic [2:0] md, input int v, input int j, input bit s);
      int r;
      r = v;
      case (md)
         3'd1: begin r = v >> j; if (s) r = r | ((255 << (8 - j)) & 255); end
         3'd2: begin r = (v << j) & 255; if (s) r = r | ((1 << j) - 1); end
         3'd4: r = ((v >> j) | (v << (8 - j))) & 255;
         3'd5: r = ((v << j) | (v >> (8 - j))) & 255;
         3'd6: begin r = v >> j; if (v >= 128) r = r | ((255 << (8 - j)) & 255); end
         default: r = v;
      endcase
      return r;
   endfunction

   // Last bit to leave v after j>=1 moves: bit j-1 going right, bit 8-j going left.
   function automatic bit ref_sout(input logic [2:0] md, input int v, input int j);
      if ((md == 3'd2) || (md == 3'd5)) return bit'((v >> (8 - j)) & 1);
      return bit'((v >> (j - 1)) & 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted operation. stall_mask bit c forces en=0 on cycle c of the shift.
   task automatic run_op(input logic [2:0] md, input int k, input int d, input bit s,
                         input logic [31:0] stall_mask, input bit pulse_start,
                         input bit b2b, output int ncyc);
      int  v;
      int  shifts;
      int  cyc;
      bit  imm;
      int  exp_o;
      bit  exp_s;
      v     = m_out;
      ncyc  = 0;
      start = 1'b1; en = 1'b1; mode = md; amt = 3'(k); data = 8'(d); sin = s;
      tick();
      start = 1'b0; mode = 3'($urandom); amt = 3'($urandom); data = 8'($urandom);
      imm = !is_shift(md) || (k == 0);
`ifdef USR_BARREL_EN
      imm = 1'b1;
`endif
      if (imm) begin
         if (md == 3'd3) exp_o = d;
         else if (md == 3'd7) exp_o = 0;
         else if (is_shift(md) && k > 0) exp_o = ref_out(md, v, k, s);
         else exp_o = v;
         exp_s = (is_shift(md) && k > 0) ? ref_sout(md, v, k) : m_sout;
         checks++; if (out !== 8'(exp_o)) begin errors++; $display("FAIL imm_out mode=%0d amt=%0d: got %h expected %h", md, k, out, 8'(exp_o)); end
         checks++; if (sout !== exp_s) begin errors++; $display("FAIL imm_sout mode=%0d: got %b expected %b", md, sout, exp_s); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL imm_busy mode=%0d: got %b expected 0", md, busy); end
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL imm_done mode=%0d: got %b expected 1", md, done); end
         m_out = exp_o; m_sout = exp_s;
      end else begin
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b expected 1", busy); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL accept_done: got %b expected 0", done); end
         checks++; if (out !== 8'(v)) begin errors++; $display("FAIL accept_out: got %h expected %h", out, 8'(v)); end
         shifts = 0; cyc = 0;
         while (shifts < k && cyc < 40) begin
            en    = (cyc < 32) ? !stall_mask[cyc] : 1'b1;
            start = pulse_start ? 1'($urandom_range(1)) : 1'b0;
            tick();
            cyc++;
            if (en) shifts++;
            exp_o = ref_out(md, v, shifts, s);
            exp_s = (shifts > 0) ? ref_sout(md, v, shifts) : m_sout;
            checks++; if (out !== 8'(exp_o)) begin errors++; $display("FAIL shift_out mode=%0d step=%0d: got %h expected %h", md, shifts, out, 8'(exp_o)); end
            checks++; if (sout !== exp_s) begin errors++; $display("FAIL shift_sout mode=%0d step=%0d: got %b expected %b", md, shifts, sout, exp_s); end
            checks++; if (busy !== (shifts < k)) begin errors++; $display("FAIL shift_busy step=%0d: got %b expected %b", shifts, busy, (shifts < k)); end
            checks++; if (done !== (shifts == k)) begin errors++; $display("FAIL shift_done step=%0d: got %b expected %b", shifts, done, (shifts == k)); end
         end
         checks++; if (shifts < k) begin errors++; $display("FAIL shift_timeout: got %0d shifts expected %0d", shifts, k); end
         start = 1'b0; en = 1'b1;
         ncyc  = cyc;
         m_out = ref_out(md, v, k, s); m_sout = ref_sout(md, v, k);
      end
      if (!b2b) begin
         en = 1'b0;
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
         checks++; if (out !== 8'(m_out)) begin errors++; $display("FAIL hold_out: got %h expected %h", out, 8'(m_out)); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
         en = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b0; start = 1'b0; mode = 3'd0; amt = 3'd0; data = 8'h00; sin = 1'b0;
      #12;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
      checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b expected 0", sout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      @(negedge clk); reset = 1'b1;
      tick();
      m_out = 0; m_sout = 1'b0;
   endtask

   task automatic test_load_srl();
      int n;
      run_op(3'd3, 0, 8'hAA, 1'b0, 32'h0, 1'b0, 1'b0, n);
      checks++; if (out !== 8'hAA) begin errors++; $display("FAIL load_aa: got %h expected aa", out); end
      run_op(3'd1, 3, 0, 1'b0, 32'h0, 1'b0, 1'b0, n);
      checks++; if (out !== 8'h15) begin errors++; $display("FAIL srl3: got %h expected 15", out); end
      checks++; if (sout !== 1'b0) begin errors++; $display("FAIL srl3_sout: got %b expected 0", sout); end
`ifndef USR_BARREL_EN
      checks++; if (n !== 3) begin errors++; $display("FAIL srl3_latency: got %0d expected 3", n); end
`endif
   endtask

   task automatic test_rol_sra();
      int n;
      run_op(3'd3, 0, 8'hA5, 1'b0, 32'h0, 1'b0, 1'b0, n);
      run_op(3'd5, 4, 0, 1'b0, 32'h0, 1'b0, 1'b0, n);
      checks++; if (out !== 8'h5A) begin errors++; $display("FAIL rol4: got %h expected 5a", out); end
      run_op(3'd3, 0, 8'h96, 1'b0, 32'h0, 1'b0, 1'b0, n);
      run_op(3'd6, 2, 0, 1'b0, 32'h0, 1'b0, 1'b0, n);
      checks++; if (out !== 8'hE5) begin errors++; $display("FAIL sra2: got %h expected e5", out); end
      checks++; if (sout !== 1'b1) begin errors++; $display("FAIL sra2_sout: got %b expected 1", sout); end
   endtask

   task automatic test_stall();
      int n;
      run_op(3'd3, 0, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, n);
      run_op(3'd1, 5, 0, 1'b0, 32'b1100, 1'b1, 1'b0, n);
      checks++; if (out !== 8'h07) begin errors++; $display("FAIL stall_srl5: got %h expected 07", out); end
`ifndef USR_BARREL_EN
      checks++; if (n !== 7) begin errors++; $display("FAIL stall_latency: got %0d expected 7", n); end
`endif
   endtask

   task automatic test_amt0_and_reset();
      int n;
      run_op(3'd3, 0, 8'h3C, 1'b0, 32'h0, 1'b0, 1'b0, n);
      run_op(3'd2, 0, 0, 1'b1, 32'h0, 1'b0, 1'b0, n);
      checks++; if (out !== 8'h3C) begin errors++; $display("FAIL sll0: got %h expected 3c", out); end
      start = 1'b1; en = 1'b1; mode = 3'd4; amt = 3'd6;
      tick();
      start = 1'b0;
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL midreset_out: got %h expected 00", out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (done !== 1'b0 || out !== 8'h00) begin errors++; $display("FAIL postreset: got done=%b out=%h expected done=0 out=00", done, out); end
      end
      m_out = 0; m_sout = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      run_op(3'd3, 0, 8'hC3, 1'b0, 32'h0, 1'b0, 1'b1, n);
      run_op(3'd2, 3, 0, 1'b1, 32'h0, 1'b0, 1'b1, n);
      run_op(3'd4, 1, 0, 1'b0, 32'h0, 1'b0, 1'b1, n);
      run_op(3'd0, 0, 8'h11, 1'b0, 32'h0, 1'b0, 1'b1, n);
      run_op(3'd5, 7, 0, 1'b0, 32'h0, 1'b1, 1'b1, n);
      run_op(3'd7, 0, 8'h55, 1'b0, 32'h0, 1'b0, 1'b1, n);
      run_op(3'd3, 0, 8'h81, 1'b0, 32'h0, 1'b0, 1'b0, n);
   endtask

   task automatic test_random();
      int n;
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom), int'($urandom_range(7)), int'($urandom_range(255)),
                1'($urandom), $urandom & $urandom, 1'($urandom), 1'($urandom), n);
      end
   endtask

   initial begin
      test_reset();
      test_load_srl();
      test_rol_sra();
      test_stall();
      test_amt0_and_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
